// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side buffer: default widths/depths
// and the feeder state encoding.
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        WAIT_ACK  = 2'b01,
        WAIT_DONE = 2'b10
    } feed_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy flags and a write-drop detect.
// The read port is combinational; the consumer registers the word on pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow
);

    localparam int CNT_WIDTH = ADDR_WIDTH + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_sync_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count_next;
    logic                  wr_accept;
    logic                  rd_accept;

    // A full FIFO drops the write even when a pop frees a slot in the same cycle.
    assign wr_accept = wr_en && !full;
    assign rd_accept = rd_en && !empty;
    assign overflow  = wr_en && full;
    assign rd_data   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + CNT_WIDTH'(1);
            2'b01:   count_next = count - CNT_WIDTH'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_WIDTH'(FIFO_DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit buffer and feeder: queues host bytes and hands them to the UART
// transmitter one at a time over its enable/busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int FIFO_DEPTH  = UART_FIFO_DEPTH,
    parameter int ACK_TIMEOUT = 15,
    localparam int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_ack_err,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_enable,
    input  logic                  i_tx_busy
);

    localparam int TMO_WIDTH = $clog2(ACK_TIMEOUT + 1);

    feed_state_t           state;
    logic [TMO_WIDTH-1:0]  tmo_cnt;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_overflow;
    logic                  issue;
    logic                  ack_timeout_hit;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (i_wr_data),
        .wr_en    (i_wr_en),
        .rd_en    (issue),
        .rd_data  (fifo_rd_data),
        .full     (o_full),
        .empty    (o_empty),
        .count    (o_count),
        .overflow (fifo_overflow)
    );

    // Pop and issue are the same event; only one byte is ever outstanding.
    assign issue = (state == IDLE) && !o_empty && !i_tx_busy;
    assign ack_timeout_hit = (state == WAIT_ACK) && !i_tx_busy &&
                             ((tmo_cnt + TMO_WIDTH'(1)) == TMO_WIDTH'(ACK_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tmo_cnt     <= '0;
            o_tx_enable <= 1'b0;
            o_tx_data   <= '0;
        end else begin
            o_tx_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        o_tx_data   <= fifo_rd_data;
                        o_tx_enable <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    // A byte that is never acknowledged is dropped, not retried.
                    if (i_tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (ack_timeout_hit) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_WIDTH'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A new error event in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_overflow <= 1'b0;
            o_ack_err  <= 1'b0;
        end else begin
            if (fifo_overflow) begin
                o_overflow <= 1'b1;
            end else if (i_clr_err) begin
                o_overflow <= 1'b0;
            end
            if (ack_timeout_hit) begin
                o_ack_err <= 1'b1;
            end else if (i_clr_err) begin
                o_ack_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a reactive transmitter model and a
// byte scoreboard checked at every issue.
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk;
    logic       rst;
    logic [7:0] i_wr_data;
    logic       i_wr_en;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_count;
    logic       o_overflow;
    logic       o_ack_err;
    logic       i_clr_err;
    logic [7:0] o_tx_data;
    logic       o_tx_enable;
    logic       i_tx_busy = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int  occ        = 0;
    int  issued     = 0;
    bit  ack_on     = 1'b1;
    bit  force_busy = 1'b0;
    int  hold_len   = 20;
    bit  pend       = 1'b0;
    bit  mbusy      = 1'b0;
    int  hold       = 0;
    logic en_prev   = 1'b0;

    uart_tx_fifo dut (
        .clk         (clk),
        .rst         (rst),
        .i_wr_data   (i_wr_data),
        .i_wr_en     (i_wr_en),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_ack_err   (o_ack_err),
        .i_clr_err   (i_clr_err),
        .o_tx_data   (o_tx_data),
        .o_tx_enable (o_tx_enable),
        .i_tx_busy   (i_tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: acts 2 time units after each edge, the stimulus at 3.
    always @(posedge clk) begin
        #2;
        if (o_tx_enable === 1'b1) begin
            check("enable_one_cycle", {31'd0, en_prev}, 32'd0);
            check("one_outstanding", {30'd0, pend, mbusy}, 32'd0);
            check("issue_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("issue_order", {24'd0, o_tx_data}, {24'd0, exp_q.pop_front()});
            end
            occ--;
            issued++;
            if (ack_on) pend = 1'b1;
        end else if (pend) begin
            pend  = 1'b0;
            mbusy = 1'b1;
            hold  = hold_len;
        end else if (mbusy) begin
            hold--;
            if (hold <= 0) mbusy = 1'b0;
        end
        en_prev   = o_tx_enable;
        i_tx_busy = mbusy | force_busy;
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bit acc;
        acc       = (occ < DEPTH);
        i_wr_data = b;
        i_wr_en   = 1'b1;
        tick();
        i_wr_en   = 1'b0;
        if (acc) begin
            exp_q.push_back(b);
            occ++;
        end
        check("wr_count", {27'd0, o_count}, occ);
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_empty !== 1'b1 || i_tx_busy !== 1'b0 ||
                pend || o_tx_enable !== 1'b0) && n < limit) begin
            tick();
            n++;
        end
        check("drain_in_time", {31'd0, n < limit}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        int issued_mark;
        bit seen_en;

        rst = 1'b1; i_wr_en = 1'b0; i_wr_data = 8'h00; i_clr_err = 1'b0;
        repeat (3) tick();
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_count", o_count, 0);
        check("rst_enable", o_tx_enable, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_ackerr", o_ack_err, 0);
        rst = 1'b0;
        tick();

        // Single byte latency, then a second byte held back by busy
        write_byte(8'hA5);
        check("t1_empty_after_wr", o_empty, 0);
        check("t1_enable_not_yet", o_tx_enable, 0);
        tick();
        check("t1_enable_high", o_tx_enable, 1);
        check("t1_data", o_tx_data, 8'hA5);
        check("t1_empty_after_pop", o_empty, 1);
        tick();
        check("t1_enable_fell", o_tx_enable, 0);
        check("t1_data_held", o_tx_data, 8'hA5);
        write_byte(8'h5A);
        drain(200);

        // Fill while busy, overflow, clear racing a new overflow, then drain
        force_busy = 1'b1;
        tick(); tick();
        issued_mark = issued;
        for (int i = 1; i <= 16; i++) write_byte(8'(i));
        check("t2_full", o_full, 1);
        check("t2_count16", o_count, 16);
        check("t2_no_ovf_yet", o_overflow, 0);
        write_byte(8'hFF);
        check("t2_ovf", o_overflow, 1);
        check("t2_count_hold", o_count, 16);
        i_clr_err = 1'b1;
        write_byte(8'hEE);
        i_clr_err = 1'b0;
        check("t6_set_wins", o_overflow, 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        check("t2_ovf_cleared", o_overflow, 0);
        force_busy = 1'b0;
        drain(1000);
        check("t2_issued16", issued - issued_mark, 16);

        // Simultaneous write and pop at count 3, then wrap across 40 bytes
        hold_len = 2;
        force_busy = 1'b1;
        tick(); tick();
        issued_mark = issued;
        for (int i = 0; i < 3; i++) write_byte(8'(8'h20 + i));
        check("t3_count3", o_count, 3);
        force_busy = 1'b0;
        tick();
        write_byte(8'h23);
        check("t3_wr_pop_count", o_count, 3);
        check("t3_wr_pop_enable", o_tx_enable, 1);
        for (int i = 0; i < 36; i++) begin
            write_byte(8'(8'h40 + i));
            tick(); tick(); tick();
        end
        drain(1000);
        check("t3_issued40", issued - issued_mark, 40);
        check("t3_no_ovf", o_overflow, 0);

        // Transmitter never acknowledges
        ack_on = 1'b0;
        write_byte(8'h77);
        write_byte(8'h88);
        n = 0;
        while (o_tx_enable !== 1'b1 && n < 50) begin tick(); n++; end
        check("t4_issue_seen", o_tx_enable, 1);
        k = 0;
        while (o_ack_err !== 1'b1 && k < 40) begin tick(); k++; end
        check("t4_ackerr_latency", k, 15);
        tick();
        check("t4_next_issue", o_tx_enable, 1);
        check("t4_next_data", o_tx_data, 8'h88);
        repeat (20) tick();
        check("t4_ackerr_sticky", o_ack_err, 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        check("t4_ackerr_cleared", o_ack_err, 0);
        ack_on = 1'b1;
        drain(200);

        // Asynchronous reset mid WAIT_DONE with 5 bytes queued
        hold_len = 20;
        for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i));
        check("t5_queued5", o_count, 5);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_count", o_count, 0);
        check("t5_async_empty", o_empty, 1);
        check("t5_async_full", o_full, 0);
        check("t5_async_enable", o_tx_enable, 0);
        check("t5_async_data", o_tx_data, 0);
        check("t5_async_ovf", o_overflow, 0);
        check("t5_async_ackerr", o_ack_err, 0);
        exp_q.delete();
        occ = 0;
        tick(); tick();
        rst = 1'b0;
        seen_en = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen_en |= o_tx_enable;
        end
        check("t5_no_enable", seen_en, 0);
        check("t5_count0", o_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
